// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM tick generator.
// Holds the controller state encoding and default WIDTH/PERIOD values.
package pwm_pkg;

    localparam int PWM_WIDTH_DEF  = 8;
    localparam int PWM_PERIOD_DEF = 100;

    typedef enum logic [1:0] {
        PWM_IDLE = 2'd0,
        PWM_RUN  = 2'd1,
        PWM_STOP = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/rise_detect.sv
// Samples the divided-clock level and emits a one-cycle tick per rising edge.
// Define PWM_TICK_SYNC2_EN to add a second sampling flop for an asynchronous tick_clk.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_clk,
    output logic tick
);

    logic w_tick_src;
    logic r_tick_q;
    logic r_tick_prev;
    logic r_tick;

`ifdef PWM_TICK_SYNC2_EN
    logic r_tick_meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_meta <= 1'b0;
        end else begin
            r_tick_meta <= tick_clk;
        end
    end

    assign w_tick_src = r_tick_meta;
`else
    assign w_tick_src = tick_clk;
`endif

    // NOTE: non-blocking assignments let every flop sample the pre-edge values,
    // which is what makes this a three-stage pipeline rather than a wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_q    <= 1'b0;
            r_tick_prev <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_tick_q    <= w_tick_src;
            r_tick_prev <= r_tick_q;
            r_tick      <= r_tick_q & ~r_tick_prev;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/pwm_tick_gen.sv
// Tick-paced PWM generator with a shadowed duty register applied at period wraps.
// Build option PWM_TICK_SYNC2_EN (honoured in rise_detect) adds a synchronizer stage.
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH  = PWM_WIDTH_DEF,
    parameter int PERIOD = PWM_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_clk,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_done,
    output logic             busy
);

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(PERIOD - 1);

    pwm_state_e       r_state;
    pwm_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_duty_shadow;
    logic [WIDTH-1:0] r_duty_act;
    logic             r_shadow_full;
    logic             r_pwm;
    logic             r_period_done;
    logic             w_tick;
    logic             w_wrap;
    logic             w_load;
    logic             w_xfer;

    rise_detect u_rise_detect (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_clk (tick_clk),
        .tick     (w_tick)
    );

    assign w_wrap = w_tick && (r_state != PWM_IDLE) && (r_cnt == CNT_LAST);
    assign w_xfer = duty_valid && !r_shadow_full;
    // A pending duty is promoted at every wrap and when leaving IDLE.
    assign w_load = r_shadow_full &&
                    (w_wrap || ((r_state == PWM_IDLE) && (w_state_nxt == PWM_RUN)));

    // NOTE: next state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PWM_IDLE: if (enable) w_state_nxt = PWM_RUN;
            PWM_RUN:  if (!enable) w_state_nxt = PWM_STOP;
            PWM_STOP: begin
                if (enable)      w_state_nxt = PWM_RUN;
                else if (w_wrap) w_state_nxt = PWM_IDLE;
            end
            default:  w_state_nxt = PWM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= PWM_IDLE;
            r_cnt         <= '0;
            r_period_done <= 1'b0;
            r_pwm         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_period_done <= w_wrap;
            r_pwm         <= (r_state != PWM_IDLE) && (r_cnt < r_duty_act);
            if (r_state == PWM_IDLE) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + WIDTH'(1);
            end
        end
    end

    // Transfer needs an empty shadow and a load needs a full one, so the two
    // never collide; a transfer on a wrap cycle waits for the next wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_shadow <= '0;
            r_shadow_full <= 1'b0;
            r_duty_act    <= '0;
        end else begin
            if (w_xfer) begin
                r_duty_shadow <= duty_in;
                r_shadow_full <= 1'b1;
            end else if (w_load) begin
                r_shadow_full <= 1'b0;
            end
            if (w_load) begin
                r_duty_act <= r_duty_shadow;
            end
        end
    end

    assign duty_ready  = !r_shadow_full;
    assign pwm_out     = r_pwm;
    assign period_done = r_period_done;
    assign busy        = (r_state != PWM_IDLE);

endmodule

// File: tb/tb_pwm_tick_gen.sv
// Directed bench for pwm_tick_gen at WIDTH=8, PERIOD=10 with a 4-cycle tick_clk.
// Expected tick latency follows PWM_TICK_SYNC2_EN when the bench is built with it.
module tb_pwm_tick_gen;

`ifdef PWM_TICK_SYNC2_EN
    localparam int TICK_LAT = 4;
`else
    localparam int TICK_LAT = 3;
`endif

    logic       clk;
    logic       rst_n;
    logic       tick_clk;
    logic       enable;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_done;
    logic       busy;

    logic       tick_run;
    logic       tick_man;
    logic       gen_lvl;
    int         gen_phase;

    int n_vec;
    int n_err;

    pwm_tick_gen #(
        .WIDTH  (8),
        .PERIOD (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_clk    (tick_clk),
        .enable      (enable),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .pwm_out     (pwm_out),
        .period_done (period_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running divided clock: 2 cycles high, 2 low, so one tick every 4 clk.
    always @(negedge clk) begin
        if (tick_run) begin
            gen_lvl   = (gen_phase < 2);
            gen_phase = (gen_phase + 1) % 4;
        end else begin
            gen_lvl   = 1'b0;
            gen_phase = 0;
        end
    end

    assign tick_clk = tick_run ? gen_lvl : tick_man;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = period_done;
        end
        check_val(tag, seen, 1);
    endtask

    // Starts on a sample with period_done high and stops on the next one.
    task automatic measure(input int wr_at, input logic [7:0] wr_val,
                           input int drop_at, input int raise_at,
                           output int hi, output int len, output int rdy_lo,
                           output logic busy_end);
        hi     = 0;
        len    = 0;
        rdy_lo = 0;
        for (int i = 0; i < 200; i++) begin
            duty_valid = (i == wr_at);
            if (i == wr_at)    duty_in = wr_val;
            if (i == drop_at)  enable  = 1'b0;
            if (i == raise_at) enable  = 1'b1;
            @(negedge clk);
            len++;
            if (pwm_out)     hi++;
            if (!duty_ready) rdy_lo++;
            if (period_done) break;
        end
        duty_valid = 1'b0;
        busy_end   = busy;
    endtask

    int   hi;
    int   len;
    int   rdy_lo;
    logic busy_end;
    int   n_pd;
    int   n_hi;
    int   n_busy;
    int   lat;

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        duty_in    = 8'd0;
        duty_valid = 1'b0;
        tick_man   = 1'b0;
        tick_run   = 1'b1;

        // Reset and idle with tick_clk toggling.
        repeat (3) @(negedge clk);
        check_val("rst_pwm",   pwm_out,     0);
        check_val("rst_busy",  busy,        0);
        check_val("rst_ready", duty_ready,  1);
        check_val("rst_pd",    period_done, 0);
        rst_n = 1'b1;
        n_pd = 0; n_hi = 0; n_busy = 0;
        repeat (60) begin
            @(negedge clk);
            if (period_done) n_pd++;
            if (pwm_out)     n_hi++;
            if (busy)        n_busy++;
        end
        check_val("idle_pd_cnt",   n_pd,       0);
        check_val("idle_pwm_hi",   n_hi,       0);
        check_val("idle_busy_cnt", n_busy,     0);
        check_val("idle_ready",    duty_ready, 1);

        // Tick latency with duty 1: pwm_out drops one edge after the first tick.
        tick_run = 1'b0;
        repeat (6) @(negedge clk);
        duty_in    = 8'd1;
        duty_valid = 1'b1;
        @(negedge clk);
        check_val("lat_shadow_full", duty_ready, 0);
        duty_valid = 1'b0;
        enable     = 1'b1;
        @(negedge clk);
        check_val("lat_busy",       busy,       1);
        check_val("lat_entry_load", duty_ready, 1);
        @(negedge clk);
        check_val("lat_pwm_high", pwm_out, 1);
        tick_man = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (!pwm_out) lat = k;
        end
        check_val("tick_latency", lat, TICK_LAT + 1);
        tick_man = 1'b0;
        enable   = 1'b0;
        tick_run = 1'b1;
        wait_done("lat_stop_wrap");
        check_val("lat_stop_idle", busy, 0);

        // Duty 3 loaded in IDLE, then run.
        duty_in    = 8'd3;
        duty_valid = 1'b1;
        @(negedge clk);
        check_val("d3_shadow_full", duty_ready, 0);
        duty_valid = 1'b0;
        enable     = 1'b1;
        @(negedge clk);
        check_val("d3_busy",       busy,       1);
        check_val("d3_entry_load", duty_ready, 1);
        wait_done("d3_first_wrap");
        measure(-1, 8'd0, -1, -1, hi, len, rdy_lo, busy_end);
        check_val("d3_hi",  hi,  12);
        check_val("d3_len", len, 40);

        // 3 -> 7 written mid-period: current period keeps 3.
        measure(10, 8'd7, -1, -1, hi, len, rdy_lo, busy_end);
        check_val("d7_wr_hi",     hi,         12);
        check_val("d7_wr_len",    len,        40);
        check_val("d7_rdy_lo",    rdy_lo,     29);
        check_val("d7_rdy_back",  duty_ready, 1);
        measure(5, 8'd0, -1, -1, hi, len, rdy_lo, busy_end);
        check_val("d7_hi",        hi,         28);
        check_val("d7_len",       len,        40);
        check_val("d0_wr_rdy_lo", rdy_lo,     34);

        // Duty 0 then duty 12 (beyond PERIOD).
        measure(5, 8'd12, -1, -1, hi, len, rdy_lo, busy_end);
        check_val("d0_hi",  hi,  0);
        check_val("d0_len", len, 40);
        measure(5, 8'd3, -1, -1, hi, len, rdy_lo, busy_end);
        check_val("d12_hi",  hi,  40);
        check_val("d12_len", len, 40);

        // Enable dropped at cnt=4: period completes, then IDLE.
        measure(-1, 8'd0, 17, -1, hi, len, rdy_lo, busy_end);
        check_val("stop_hi",   hi,       12);
        check_val("stop_len",  len,      40);
        check_val("stop_idle", busy_end, 0);
        n_pd = 0; n_hi = 0;
        repeat (60) begin
            @(negedge clk);
            if (period_done) n_pd++;
            if (pwm_out)     n_hi++;
        end
        check_val("stopped_pd_cnt", n_pd, 0);
        check_val("stopped_pwm_hi", n_hi, 0);

        // Enable dropped at cnt=4 and re-raised at cnt=8: no gap.
        enable = 1'b1;
        wait_done("resume_first_wrap");
        measure(-1, 8'd0, 17, 33, hi, len, rdy_lo, busy_end);
        check_val("resume_hi",   hi,       12);
        check_val("resume_len",  len,      40);
        check_val("resume_busy", busy_end, 1);
        measure(5, 8'd7, -1, -1, hi, len, rdy_lo, busy_end);
        check_val("resume_next_hi",  hi,  12);
        check_val("resume_next_len", len, 40);

        // Reset at cnt=5 of a duty-7 period with duty 2 pending in the shadow.
        for (int i = 0; i <= 20; i++) begin
            duty_valid = (i == 5);
            duty_in    = 8'd2;
            @(negedge clk);
        end
        duty_valid = 1'b0;
        check_val("pre_rst_pwm",   pwm_out,    1);
        check_val("pre_rst_ready", duty_ready, 0);
        rst_n = 1'b0;
        #1;
        check_val("arst_pwm",   pwm_out,     0);
        check_val("arst_busy",  busy,        0);
        check_val("arst_ready", duty_ready,  1);
        check_val("arst_pd",    period_done, 0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        wait_done("post_rst_wrap");
        measure(-1, 8'd0, -1, -1, hi, len, rdy_lo, busy_end);
        check_val("post_rst_hi",   hi,       0);
        check_val("post_rst_len",  len,      40);
        check_val("post_rst_busy", busy_end, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
